// File: rtl/game_pkg.sv
// game_pkg: shared types, block schedule and tuning constants for the block-slicing game
package game_pkg;
  localparam int TIME_W      = 16;
  localparam int TICK_CYCLES = 10;
  localparam int NUM_BLOCKS  = 4;
  localparam int HALF_MAX    = 32;
  localparam int HALF_MIN    = 4;
  localparam int LOOKAHEAD   = 100;
  localparam int HIT_WINDOW  = 5;
  localparam int SABER_R     = 3;
  localparam int DZ_MAX      = (HALF_MAX - HALF_MIN) * 4;

  typedef struct packed {
    logic [11:0]       x;
    logic [11:0]       y;
    logic [TIME_W-1:0] t_hit;
    logic              side;
  } block_t;

  localparam block_t [NUM_BLOCKS-1:0] BLOCK_TABLE = {
    block_t'{x: 12'd100, y: 12'd400, t_hit: 16'd250, side: 1'b1},
    block_t'{x: 12'd400, y: 12'd200, t_hit: 16'd150, side: 1'b1},
    block_t'{x: 12'd200, y: 12'd300, t_hit: 16'd100, side: 1'b0},
    block_t'{x: 12'd200, y: 12'd200, t_hit: 16'd10,  side: 1'b0}
  };

  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_WHITE = {5'd31, 6'd63, 5'd31};
  localparam logic [15:0] RGB_RED   = {5'd31, 6'd0, 5'd0};
  localparam logic [15:0] RGB_BLUE  = {5'd0, 6'd0, 5'd31};

  function automatic logic [12:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction
endpackage

// File: rtl/game_logic_renderer_block_projector.sv
// block_projector: visibility, perspective half-size and hit/miss timing for one block
module block_projector
  import game_pkg::*;
(
  input  logic [TIME_W-1:0] curr_time,
  input  logic [TIME_W-1:0] t_hit,
  output logic              visible,
  output logic [5:0]        half,
  output logic              in_window,
  output logic              late
);
  localparam int TW = TIME_W + 2;
  logic [TW-1:0] t, th, dz, dzc;
  // widened time comparisons so nothing underflows near time zero
  always_comb begin
    t         = {2'b0, curr_time};
    th        = {2'b0, t_hit};
    visible   = (t + TW'(LOOKAHEAD)) >= th;
    in_window = ((t + TW'(HIT_WINDOW)) >= th) && (t <= (th + TW'(HIT_WINDOW)));
    late      = t > (th + TW'(HIT_WINDOW));
    dz        = (th > t) ? (th - t) : '0;
    dzc       = (dz > TW'(DZ_MAX)) ? TW'(DZ_MAX) : dz;
    half      = 6'(TW'(HALF_MAX) - (dzc >> 2));
  end
endmodule

// File: rtl/game_logic_renderer.sv
// game_logic_renderer: game clock, block hit/miss tracking and RGB565 pixel generation
module game_logic_renderer
  import game_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic [11:0] hand_x_left_bottom,
  input  logic [11:0] hand_y_left_bottom,
  input  logic [13:0] hand_z_left_bottom,
  input  logic [11:0] hand_x_left_top,
  input  logic [11:0] hand_y_left_top,
  input  logic [13:0] hand_z_left_top,
  input  logic [11:0] hand_x_right_bottom,
  input  logic [11:0] hand_y_right_bottom,
  input  logic [13:0] hand_z_right_bottom,
  input  logic [11:0] hand_x_right_top,
  input  logic [11:0] hand_y_right_top,
  input  logic [13:0] hand_z_right_top,
  input  logic [11:0] head_x,
  input  logic [11:0] head_y,
  input  logic [13:0] head_z,
  output logic [4:0]  r_out,
  output logic [5:0]  g_out,
  output logic [4:0]  b_out
);
  localparam int TICK_W = $clog2(TICK_CYCLES);
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [TIME_W-1:0]     curr_time_q, curr_time_d, curr_time;
  logic [NUM_BLOCKS-1:0] active_q, active_d, vis, win, late, hit, miss;
  logic [5:0]            half [NUM_BLOCKS];
  logic [7:0]            score_q, score_d, misses_q, misses_d;
  logic [2:0]            n_hit, n_miss;
  logic [8:0]            s_sum, m_sum;
  logic [10:0]           x_q;
  logic [9:0]            y_q;
  logic [11:0]           lx_q, ly_q, rx_q, ry_q;
  logic [15:0]           rgb_q, rgb_d;
  logic [141:0]          aux_q;
  logic                  unused_aux;
  logic                  saber;

  assign curr_time  = curr_time_q;
  assign unused_aux = ^aux_q;
  assign {r_out, g_out, b_out} = rgb_q;

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
    block_projector u_proj (
      .curr_time(curr_time),
      .t_hit    (BLOCK_TABLE[i].t_hit),
      .visible  (vis[i]),
      .half     (half[i]),
      .in_window(win[i]),
      .late     (late[i])
    );
  end

  // game clock: tick prescaler and wrapping time counter
  always_comb begin
    tick_d      = (tick_q == TICK_W'(TICK_CYCLES - 1)) ? '0 : tick_q + 1'b1;
    curr_time_d = (tick_q == TICK_W'(TICK_CYCLES - 1)) ? curr_time_q + 1'b1 : curr_time_q;
  end

  // per-block hit/miss retirement and saturating score/miss counters
  always_comb begin
    active_d = active_q;
    hit      = '0;
    miss     = '0;
    n_hit    = '0;
    n_miss   = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      hit[i]  = active_q[i] && win[i]
             && abs_diff(BLOCK_TABLE[i].side ? rx_q : lx_q, BLOCK_TABLE[i].x) < 13'(HALF_MAX)
             && abs_diff(BLOCK_TABLE[i].side ? ry_q : ly_q, BLOCK_TABLE[i].y) < 13'(HALF_MAX);
      miss[i] = active_q[i] && late[i];
      active_d[i] = active_q[i] && !hit[i] && !miss[i];
      n_hit  = n_hit + {2'b0, hit[i]};
      n_miss = n_miss + {2'b0, miss[i]};
    end
    s_sum    = {1'b0, score_q} + {6'b0, n_hit};
    m_sum    = {1'b0, misses_q} + {6'b0, n_miss};
    score_d  = s_sum[8] ? 8'hff : s_sum[7:0];
    misses_d = m_sum[8] ? 8'hff : m_sum[7:0];
  end

  // stage-2 colour: saber marker over lowest-index covering block over black
  always_comb begin
    rgb_d = RGB_BLACK;
    saber = (abs_diff({1'b0, x_q}, lx_q) <= 13'(SABER_R) && abs_diff({2'b0, y_q}, ly_q) <= 13'(SABER_R))
         || (abs_diff({1'b0, x_q}, rx_q) <= 13'(SABER_R) && abs_diff({2'b0, y_q}, ry_q) <= 13'(SABER_R));
    for (int i = NUM_BLOCKS - 1; i >= 0; i--)
      if (active_q[i] && vis[i]
          && abs_diff({1'b0, x_q}, BLOCK_TABLE[i].x) < {7'b0, half[i]}
          && abs_diff({2'b0, y_q}, BLOCK_TABLE[i].y) < {7'b0, half[i]})
        rgb_d = BLOCK_TABLE[i].side ? RGB_BLUE : RGB_RED;
    rgb_d = saber ? RGB_WHITE : rgb_d;
  end

  // state registers and pixel pipeline with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      tick_q      <= '0;
      curr_time_q <= '0;
      active_q    <= '1;
      score_q     <= '0;
      misses_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      lx_q        <= '0;
      ly_q        <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      aux_q       <= '0;
      rgb_q       <= '0;
    end else begin
      tick_q      <= tick_d;
      curr_time_q <= curr_time_d;
      active_q    <= active_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      x_q         <= x_in;
      y_q         <= y_in;
      lx_q        <= hand_x_left_top;
      ly_q        <= hand_y_left_top;
      rx_q        <= hand_x_right_top;
      ry_q        <= hand_y_right_top;
      aux_q       <= {hand_z_left_bottom, hand_z_left_top, hand_z_right_bottom, hand_z_right_top,
                      hand_x_left_bottom, hand_y_left_bottom, hand_x_right_bottom, hand_y_right_bottom,
                      head_x, head_y, head_z};
      rgb_q       <= rgb_d;
    end
  end
endmodule

// File: tb/tb_game_logic_renderer.sv
// tb_game_logic_renderer: directed checks of game timing, hits, misses and pixel colours
module tb_game_logic_renderer;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic [11:0] hand_x_left_bottom, hand_y_left_bottom, hand_x_left_top, hand_y_left_top;
  logic [11:0] hand_x_right_bottom, hand_y_right_bottom, hand_x_right_top, hand_y_right_top;
  logic [13:0] hand_z_left_bottom, hand_z_left_top, hand_z_right_bottom, hand_z_right_top;
  logic [11:0] head_x, head_y;
  logic [13:0] head_z;
  logic [4:0]  r_out;
  logic [5:0]  g_out;
  logic [4:0]  b_out;
  int checks = 0;
  int errors = 0;

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] RED   = 16'hF800;
  localparam logic [15:0] BLUE  = 16'h001F;

  game_logic_renderer dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .hand_x_left_bottom(hand_x_left_bottom), .hand_y_left_bottom(hand_y_left_bottom),
    .hand_z_left_bottom(hand_z_left_bottom),
    .hand_x_left_top(hand_x_left_top), .hand_y_left_top(hand_y_left_top),
    .hand_z_left_top(hand_z_left_top),
    .hand_x_right_bottom(hand_x_right_bottom), .hand_y_right_bottom(hand_y_right_bottom),
    .hand_z_right_bottom(hand_z_right_bottom),
    .hand_x_right_top(hand_x_right_top), .hand_y_right_top(hand_y_right_top),
    .hand_z_right_top(hand_z_right_top),
    .head_x(head_x), .head_y(head_y), .head_z(head_z),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic px(input string tag, input logic [10:0] x, input logic [9:0] y, input logic [15:0] exp);
    x_in = x;
    y_in = y;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check(tag, 32'({r_out, g_out, b_out}), 32'(exp));
  endtask

  task automatic wait_time(input logic [15:0] t);
    int n;
    n = 0;
    while (dut.curr_time !== t && n < 20000) begin
      @(negedge clk_in);
      n++;
    end
    check("wait_time", 32'(dut.curr_time), 32'(t));
  endtask

  initial begin
    rst_in = 1'b0;
    x_in = '0; y_in = '0;
    hand_x_left_bottom = '0; hand_y_left_bottom = '0; hand_z_left_bottom = '0;
    hand_x_left_top = '0; hand_y_left_top = '0; hand_z_left_top = '0;
    hand_x_right_bottom = '0; hand_y_right_bottom = '0; hand_z_right_bottom = '0;
    hand_x_right_top = '0; hand_y_right_top = '0; hand_z_right_top = '0;
    head_x = '0; head_y = '0; head_z = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_rgb", 32'({r_out, g_out, b_out}), 32'(0));
    check("rst_time", 32'(dut.curr_time), 32'(0));
    rst_in = 1'b1;
    repeat (60) @(posedge clk_in);
    @(negedge clk_in);
    check("time_after_60", 32'(dut.curr_time), 32'(6));
    px("blk0_center", 11'd200, 10'd200, RED);
    px("blk0_edge_in", 11'd230, 10'd200, RED);
    px("blk0_edge_out", 11'd231, 10'd200, BLACK);
    hand_x_left_top = 12'd200;
    hand_y_left_top = 12'd200;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("blk0_hit_score", 32'(dut.score_q), 32'(1));
    check("blk0_hit_active", 32'(dut.active_q), 32'(4'b1110));
    px("saber_center", 11'd200, 10'd200, WHITE);
    px("saber_corner", 11'd203, 10'd203, WHITE);
    px("saber_out", 11'd204, 10'd200, BLACK);
    px("blk0_gone", 11'd210, 10'd200, BLACK);
    wait_time(16'd49);
    px("blk2_hidden", 11'd400, 10'd200, BLACK);
    wait_time(16'd50);
    px("blk2_visible", 11'd400, 10'd200, BLUE);
    px("blk1_edge_in", 11'd219, 10'd300, RED);
    px("blk1_edge_out", 11'd220, 10'd300, BLACK);
    wait_time(16'd95);
    hand_x_left_top = 12'd200;
    hand_y_left_top = 12'd300;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("blk1_hit_score", 32'(dut.score_q), 32'(2));
    check("blk1_hit_active", 32'(dut.active_q), 32'(4'b1100));
    wait_time(16'd100);
    hand_x_left_top = 12'd9;
    hand_y_left_top = 12'd9;
    wait_time(16'd105);
    hand_x_left_top = 12'd55;
    hand_y_left_top = 12'd55;
    wait_time(16'd155);
    px("blk2_at_hit", 11'd400, 10'd200, BLUE);
    check("score_stable", 32'(dut.score_q), 32'(2));
    wait_time(16'd157);
    px("blk2_missed_px", 11'd400, 10'd200, BLACK);
    check("blk2_miss_count", 32'(dut.misses_q), 32'(1));
    check("blk2_miss_active", 32'(dut.active_q), 32'(4'b1000));
    wait_time(16'd300);
    check("final_misses", 32'(dut.misses_q), 32'(2));
    check("final_score", 32'(dut.score_q), 32'(2));
    check("final_active", 32'(dut.active_q), 32'(0));
    rst_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    check("rst2_time", 32'(dut.curr_time), 32'(0));
    check("rst2_active", 32'(dut.active_q), 32'(4'b1111));
    check("rst2_score", 32'(dut.score_q), 32'(0));
    check("rst2_misses", 32'(dut.misses_q), 32'(0));
    rst_in = 1'b1;
    wait_time(16'd120);
    check("mid_misses", 32'(dut.misses_q), 32'(2));
    check("mid_active", 32'(dut.active_q), 32'(4'b1100));
    rst_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    check("rst3_time", 32'(dut.curr_time), 32'(0));
    check("rst3_active", 32'(dut.active_q), 32'(4'b1111));
    check("rst3_misses", 32'(dut.misses_q), 32'(0));
    check("rst3_rgb", 32'({r_out, g_out, b_out}), 32'(0));
    rst_in = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_logic_renderer.md
Name: game_logic_renderer

Overview:
- Core of the block-slicing game: keeps game time, tracks a fixed schedule of incoming blocks, detects hand-tip hits, and produces one RGB565 pixel for the (x,y) presented by the video timing generator.
- Sits between the camera/tracking pipeline (hand and head coordinates) and the VGA output stage.

Parameters:
- TICK_CYCLES, 10, clock cycles per game-time unit.
- NUM_BLOCKS, 4, entries in the block schedule.
- HALF_MAX, 32, on-screen half-size of a block (px) at its hit time.
- HALF_MIN, 4, minimum on-screen half-size.
- LOOKAHEAD, 100, time units before t_hit at which a block becomes visible.
- HIT_WINDOW, 5, allowed ± time units around t_hit for a hit.
- SABER_R, 3, half-size (px) of the hand-tip marker square.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-low reset
- x_in  in  11  current pixel column (hcount)
- y_in  in  10  current pixel row (vcount)
- hand_x_left_bottom, hand_y_left_bottom  in  12 each  left hand base (x,y)
- hand_z_left_bottom  in  14  left hand base depth
- hand_x_left_top, hand_y_left_top  in  12 each  left hand tip (x,y)
- hand_z_left_top  in  14  left hand tip depth
- hand_x_right_bottom, hand_y_right_bottom, hand_z_right_bottom  in  12/12/14  right hand base
- hand_x_right_top, hand_y_right_top, hand_z_right_top  in  12/12/14  right hand tip
- head_x, head_y, head_z  in  12/12/14  head position
- r_out  out  5  red
- g_out  out  6  green
- b_out  out  5  blue

Behaviour:
- Reset (rst_in==0 on a clock edge): curr_time=0, tick counter=0, all blocks active, score=0, misses=0, r/g/b_out=0.
- Tick counter counts 0..TICK_CYCLES-1. curr_time (16-bit internal register, named curr_time, visible to benches) increments when the counter wraps, i.e. once every 10 cycles. It wraps at 2^16.
- Block schedule is constant, per block: x, y, t_hit, side (0=left, 1=right).
  - block0 (200,200,t=10,left)
  - block1 (200,300,t=100,left)
  - block2 (400,200,t=150,right)
  - block3 (100,400,t=250,right)
- Visible: block active and curr_time+LOOKAHEAD >= t_hit. Use widened arithmetic; no underflow.
- Depth: dz = t_hit - curr_time if positive, else 0. Half-size = HALF_MAX - min(dz,112)/4, which gives HALF_MIN at dz >= 112.
- Hit, checked every cycle: block active, curr_time within [t_hit-HIT_WINDOW, t_hit+HIT_WINDOW], and the tip of the block's side hand satisfies |hx-bx| < HALF_MAX and |hy-by| < HALF_MAX. On a hit, the next edge clears active and increments score (8-bit, saturating).
- Miss: block active and curr_time > t_hit+HIT_WINDOW. The next edge clears active and increments misses (saturating).
- Multiple blocks may be hit or missed in the same cycle. Each block is evaluated independently. Score increments by the count of hits, saturating.
- z inputs, bottom hand points and head inputs are registered but do not affect output in this revision.
- Pixel pipeline: x_in/y_in and hand tips are registered at stage 1. Colour is registered at stage 2. Latency is 2 cycles from x_in/y_in to r/g/b_out.
- Colour priority, highest first:
  - Pixel within SABER_R (inclusive) of the left or right tip: white (31,63,31).
  - Else the lowest-index visible block whose square (|x-bx| < half, |y-by| < half) covers the pixel: red (31,0,0) if side=left, blue (0,0,31) if side=right.
  - Else black.
- Comparisons use signed, widened differences. Tip coordinates above the 11/10-bit screen range simply never match.

Decomposition:
- Package game_pkg: block record typedef (x, y, t_hit, side), BLOCK_TABLE constant array, RGB565 colour constants, time width.
- One sub-module block_projector, instantiated per block. Inputs: curr_time and block record. Outputs: visible, half-size, in-window flag.

Test Plan:
- Reset held 2 cycles, then released → curr_time=0. After 60 cycles curr_time=6; after 1000 cycles curr_time=100 (±1). Outputs 0 during reset.
- All hand tips at (0,0), x/y=(200,200), curr_time=6 → block0 visible, half=31, output red (31,0,0) two cycles after x/y are applied.
- Left tip set to (200,200) from curr_time 6 → block0 hit once curr_time reaches 5+ (within window, ≤15). Score=1, block0 no longer drawn; pixel (200,200) is white (saber).
- Left tip (200,300) from time 95 to 100 → block1 hit, score=2. Tip moved to (9,9) at 100, then (55,55) at 105 → no further score change.
- Blocks 2/3 with no right-hand tip inside them → marked missed once curr_time exceeds 155 and 255; misses=2 by time 300; pixel (400,200) black after time 155.
- rst_in low mid-game (time ~120) → curr_time=0, all blocks active again, score=0 on the next edge.
